regbank_bus_arbiter: RTL and testbench
======================================

Name: regbank_bus_arbiter

Overview:
- Sequences a bank of NrOfRegs shared-bus tri-state registers. Each register has clock enable, Tick, an active-high cs that forces Hi-Z, and a Q output on one resolved bus.
- Arbitrates read/write transactions from NrOfRequesters masters with round-robin priority.
- Generates per-register ClockEnable and cs strobes, so at most one register drives the bus and at most one captures per transaction.
- Sits between the datapath control logic and the register bank.

Parameters:
NrOfRequesters, 4, number of requesting masters (>=2)
NrOfRegs, 8, registers in the bank (<= 2**AddrBits)
NrOfBits, 4, register/bus data width
AddrBits, 3, register address width

Ports:
Clock  in  1  system clock, rising-edge
Reset  in  1  asynchronous, active-high reset
Tick  in  1  global advance enable; FSM and pointer update only on Clock edges with Tick=1
req  in  NrOfRequesters  per-requester transaction request, level, held until done
req_we  in  NrOfRequesters  per-requester 1=write, 0=read
req_addr  in  NrOfRequesters*AddrBits  packed addresses, requester i at [i*AddrBits +: AddrBits]
req_wdata  in  NrOfRequesters*NrOfBits  packed write data, requester i at [i*NrOfBits +: NrOfBits]
bus_q  in  NrOfBits  resolved shared register output bus
grant  out  NrOfRequesters  one-hot owner of current transaction
done  out  1  one-cycle completion pulse for granted requester
err  out  1  pulses with done when the latched address >= NrOfRegs
rdata  out  NrOfBits  read result, valid while done=1, then held
busy  out  1  1 when state != IDLE
reg_ce  out  NrOfRegs  register ClockEnable strobes, at most one hot
reg_cs  out  NrOfRegs  register cs; 1=Hi-Z; at most one bit 0
reg_d  out  NrOfBits  write data to all register D inputs

Behaviour:
- Reset (async, any state): state=IDLE, grant=0, done=0, err=0, rdata=0, busy=0, reg_ce=0, reg_cs=all 1, reg_d=0, rr_ptr=NrOfRequesters-1 (requester 0 wins first).
- States: IDLE, ACCESS, DONE. All transitions require a rising Clock edge with Tick=1. With Tick=0 the state, latches and outputs hold.
- IDLE: if any req is set, select the winner by round-robin, searching from rr_ptr+1 upward with wrap.
  - Latch winner index, we, addr and wdata.
  - Set grant one-hot and rr_ptr=winner, then go to ACCESS.
  - With no requests, stay in IDLE.
- ACCESS (combinational decode from latched values):
  - Write, addr valid: reg_ce[addr]=1, reg_d=wdata, reg_cs all 1.
  - Read, addr valid: reg_cs[addr]=0, reg_ce=0.
  - Invalid addr: no strobes asserted.
  - On the Tick edge: the register captures (write); rdata<=bus_q (read); rdata<=0 (invalid addr). Then go to DONE.
- DONE: done=1 and err set per addr; grant is still held, all strobes are inactive. On the Tick edge go to IDLE, and grant, done and err clear.
- Latency with Tick=1 continuously:
  - grant rises 1 cycle after req is sampled.
  - write/read happens at the 2nd edge.
  - done is high in the 3rd cycle.
  - Throughput is 1 transaction per 3 Tick edges.
- Requester protocol: drop req at the edge where done is sampled high. If req is still high in IDLE, that is a new request.
- req deasserted mid-transaction: the transaction completes anyway, because its values are latched.
- reg_d holds the last written wdata outside ACCESS-write.
- Invariants, asserted in the bench:
  - popcount(reg_ce) <= 1.
  - popcount(~reg_cs) <= 1.
  - reg_ce and ~reg_cs are never both nonzero.
  - popcount(grant) <= 1.
- Changes to req_* inputs after the IDLE sampling edge are ignored.

Test Plan:
- Reset: assert Reset mid-simulation -> immediately grant=0, reg_cs=8'hFF, reg_ce=0, done=0, busy=0, rdata=0.
- Write then read: req0 writes 4'hA to addr 5, then req0 reads addr 5 with a bank model on bus_q.
  - Write: reg_ce=8'h20 for exactly one cycle, reg_d=4'hA.
  - Read: reg_cs=8'hDF for one cycle, done in cycle 3, rdata=4'hA.
- Round-robin: all 4 req held high, Tick=1 -> grant order 0001, 0010, 0100, 1000, 0001.
  - Each grant lasts 2 cycles.
  - A new grant follows each IDLE.
- Tick gating: Tick high 1 of every 3 cycles during a write -> reg_ce is held across the non-Tick cycles.
  - The register captures exactly once.
  - done pulse lasts 3 Clock cycles and ends on the next Tick edge.
- Out-of-range: NrOfRegs=6, read addr 7 -> reg_cs all 1, reg_ce=0, done=1 with err=1, rdata=0.
- Async reset during ACCESS of a write to addr 2 -> reg_ce drops without waiting for a Clock edge; register 2 is not written; the next request goes to requester 0 first.

Source files
------------

// File: rtl/regbank_bus_arbiter_if.sv
// Handshake and register-bank bus bundle for regbank_bus_arbiter.
// slave is the arbiter's view; master is the requester/register-bank side.
interface regbank_bus_arbiter_if #(
  parameter int NrOfRequesters = 4,
  parameter int NrOfRegs       = 8,
  parameter int NrOfBits       = 4,
  parameter int AddrBits       = 3
);
  logic [NrOfRequesters-1:0]          req;
  logic [NrOfRequesters-1:0]          req_we;
  logic [NrOfRequesters*AddrBits-1:0] req_addr;
  logic [NrOfRequesters*NrOfBits-1:0] req_wdata;
  logic [NrOfBits-1:0]                bus_q;
  logic [NrOfRequesters-1:0]          grant;
  logic                               done;
  logic                               err;
  logic [NrOfBits-1:0]                rdata;
  logic                               busy;
  logic [NrOfRegs-1:0]                reg_ce;
  logic [NrOfRegs-1:0]                reg_cs;
  logic [NrOfBits-1:0]                reg_d;

  modport slave (
    input  req, req_we, req_addr, req_wdata, bus_q,
    output grant, done, err, rdata, busy, reg_ce, reg_cs, reg_d
  );

  modport master (
    output req, req_we, req_addr, req_wdata, bus_q,
    input  grant, done, err, rdata, busy, reg_ce, reg_cs, reg_d
  );
endinterface

// File: rtl/regbank_bus_arbiter.sv
// Round-robin arbiter sequencing read/write transactions onto a bank of
// shared-bus tri-state registers (IDLE -> ACCESS -> DONE, Tick-gated).
module regbank_bus_arbiter #(
  parameter int NrOfRequesters = 4,
  parameter int NrOfRegs       = 8,
  parameter int NrOfBits       = 4,
  parameter int AddrBits       = 3
) (
  input logic                   Clock,
  input logic                   Reset,
  input logic                   Tick,
  regbank_bus_arbiter_if.slave  bif
);

  localparam int IdxW = (NrOfRequesters > 1) ? $clog2(NrOfRequesters) : 1;
  localparam logic [AddrBits:0] RegsLim = (AddrBits+1)'(NrOfRegs);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e                    state_q, state_d;
  logic [IdxW-1:0]           rr_ptr_q, rr_ptr_d;
  logic                      we_q, we_d;
  logic [AddrBits-1:0]       addr_q, addr_d;
  logic [NrOfRequesters-1:0] grant_q, grant_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic [NrOfBits-1:0]       rdata_q, rdata_d;
  logic                      busy_q, busy_d;
  logic [NrOfRegs-1:0]       reg_ce_q, reg_ce_d;
  logic [NrOfRegs-1:0]       reg_cs_q, reg_cs_d;
  logic [NrOfBits-1:0]       reg_d_q, reg_d_d;

  logic                      found;
  logic [IdxW-1:0]           win;
  logic [IdxW-1:0]           idx;
  logic [AddrBits-1:0]       new_addr;
  logic [NrOfBits-1:0]       new_wdata;
  logic                      new_we;
  logic                      new_valid;
  logic                      addr_valid;

  function automatic logic [NrOfRegs-1:0] decode(input logic [AddrBits-1:0] a);
    logic [NrOfRegs-1:0] oh;
    oh = '0;
    for (int unsigned r = 0; r < NrOfRegs; r++) begin
      if (a == AddrBits'(r)) oh[r] = 1'b1;
    end
    return oh;
  endfunction

  // Round-robin search starts one past the last winner and wraps.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= NrOfRequesters; k++) begin
      idx = IdxW'((32'(rr_ptr_q) + k) % 32'(NrOfRequesters));
      if (!found && bif.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    new_addr   = bif.req_addr[win*AddrBits +: AddrBits];
    new_wdata  = bif.req_wdata[win*NrOfBits +: NrOfBits];
    new_we     = bif.req_we[win];
    new_valid  = ({1'b0, new_addr} < RegsLim);
    addr_valid = ({1'b0, addr_q} < RegsLim);
  end

  // Strobes are registered on entry to ACCESS, so they are glitch-free and
  // still drop immediately on the asynchronous reset.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    we_d     = we_q;
    addr_d   = addr_q;
    grant_d  = grant_q;
    done_d   = done_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    busy_d   = busy_q;
    reg_ce_d = reg_ce_q;
    reg_cs_d = reg_cs_q;
    reg_d_d  = reg_d_q;
    if (Tick) begin
      case (state_q)
        IDLE: begin
          if (found) begin
            state_d      = ACCESS;
            rr_ptr_d     = win;
            we_d         = new_we;
            addr_d       = new_addr;
            grant_d      = '0;
            grant_d[win] = 1'b1;
            busy_d       = 1'b1;
            if (new_valid) begin
              if (new_we) begin
                reg_ce_d = decode(new_addr);
                reg_d_d  = new_wdata;
              end else begin
                reg_cs_d = ~decode(new_addr);
              end
            end
          end
        end
        ACCESS: begin
          state_d  = DONE;
          reg_ce_d = '0;
          reg_cs_d = '1;
          done_d   = 1'b1;
          err_d    = !addr_valid;
          if (!addr_valid)  rdata_d = '0;
          else if (!we_q)   rdata_d = bif.bus_q;
        end
        DONE: begin
          state_d = IDLE;
          grant_d = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= IdxW'(NrOfRequesters - 1);
      we_q     <= 1'b0;
      addr_q   <= '0;
      grant_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      reg_ce_q <= '0;
      reg_cs_q <= '1;
      reg_d_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      reg_ce_q <= reg_ce_d;
      reg_cs_q <= reg_cs_d;
      reg_d_q  <= reg_d_d;
    end
  end

  assign bif.grant  = grant_q;
  assign bif.done   = done_q;
  assign bif.err    = err_q;
  assign bif.rdata  = rdata_q;
  assign bif.busy   = busy_q;
  assign bif.reg_ce = reg_ce_q;
  assign bif.reg_cs = reg_cs_q;
  assign bif.reg_d  = reg_d_q;

endmodule

// File: tb/tb_regbank_bus_arbiter.sv
// Directed bench for regbank_bus_arbiter: an 8-register bank model on one
// instance, and a 6-register instance for out-of-range addressing.
module tb_regbank_bus_arbiter;

  logic Clock;
  logic Reset;
  logic Tick;
  int   checks;
  int   failures;

  regbank_bus_arbiter_if #(.NrOfRequesters(4), .NrOfRegs(8), .NrOfBits(4), .AddrBits(3)) bif ();
  regbank_bus_arbiter_if #(.NrOfRequesters(4), .NrOfRegs(6), .NrOfBits(4), .AddrBits(3)) bif6 ();

  regbank_bus_arbiter #(.NrOfRequesters(4), .NrOfRegs(8), .NrOfBits(4), .AddrBits(3)) u_dut (
    .Clock (Clock),
    .Reset (Reset),
    .Tick  (Tick),
    .bif   (bif.slave)
  );

  regbank_bus_arbiter #(.NrOfRequesters(4), .NrOfRegs(6), .NrOfBits(4), .AddrBits(3)) u_dut6 (
    .Clock (Clock),
    .Reset (Reset),
    .Tick  (Tick),
    .bif   (bif6.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Register bank model: capture on ClockEnable with Tick, drive bus when cs=0.
  logic [3:0] bank   [8] = '{default: 4'h0};
  int         wcount [8] = '{default: 0};

  always @(posedge Clock) begin
    for (int r = 0; r < 8; r++) begin
      if (Tick && bif.reg_ce[r]) begin
        bank[r]   <= bif.reg_d;
        wcount[r] <= wcount[r] + 1;
      end
    end
  end

  always_comb begin
    bif.bus_q = 4'bzzzz;
    for (int r = 0; r < 8; r++) begin
      if (!bif.reg_cs[r]) bif.bus_q = bank[r];
    end
  end

  assign bif6.bus_q = 4'hC;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  always @(negedge Clock) begin
    logic ok;
    ok = ($countones(bif.reg_ce) <= 1) && ($countones(~bif.reg_cs) <= 1) &&
         !((bif.reg_ce != '0) && (~bif.reg_cs != '0)) && ($countones(bif.grant) <= 1);
    chk("invariant8", 32'(ok), 32'd1);
    ok = ($countones(bif6.reg_ce) <= 1) && ($countones(~bif6.reg_cs) <= 1) &&
         !((bif6.reg_ce != '0) && (~bif6.reg_cs != '0)) && ($countones(bif6.grant) <= 1);
    chk("invariant6", 32'(ok), 32'd1);
  end

  initial begin
    logic [31:0] exp;
    checks   = 0;
    failures = 0;
    Reset = 1'b1;
    Tick  = 1'b1;
    bif.req  = '0; bif.req_we  = '0; bif.req_addr  = '0; bif.req_wdata  = '0;
    bif6.req = '0; bif6.req_we = '0; bif6.req_addr = '0; bif6.req_wdata = '0;
    step();
    step();
    chk("rst_grant", 32'(bif.grant), 32'h0);
    chk("rst_cs", 32'(bif.reg_cs), 32'hFF);
    chk("rst_ce", 32'(bif.reg_ce), 32'h0);
    chk("rst_done", 32'(bif.done), 32'h0);
    chk("rst_busy", 32'(bif.busy), 32'h0);
    chk("rst_rdata", 32'(bif.rdata), 32'h0);
    chk("rst_err", 32'(bif.err), 32'h0);
    chk("rst_d", 32'(bif.reg_d), 32'h0);
    Reset = 1'b0;

    // Requester 0 writes 4'hA to address 5
    bif.req = 4'b0001; bif.req_we = 4'b0001;
    bif.req_addr[2:0] = 3'd5; bif.req_wdata[3:0] = 4'hA;
    step();
    chk("wr_grant", 32'(bif.grant), 32'h1);
    chk("wr_ce", 32'(bif.reg_ce), 32'h20);
    chk("wr_d", 32'(bif.reg_d), 32'hA);
    chk("wr_cs", 32'(bif.reg_cs), 32'hFF);
    chk("wr_busy", 32'(bif.busy), 32'h1);
    step();
    chk("wr_ce_off", 32'(bif.reg_ce), 32'h0);
    chk("wr_done", 32'(bif.done), 32'h1);
    chk("wr_err", 32'(bif.err), 32'h0);
    chk("wr_grant_hold", 32'(bif.grant), 32'h1);
    chk("wr_bank5", 32'(bank[5]), 32'hA);
    chk("wr_count5", 32'(wcount[5]), 32'd1);
    bif.req = 4'b0000;
    step();
    chk("wr_done_clr", 32'(bif.done), 32'h0);
    chk("wr_grant_clr", 32'(bif.grant), 32'h0);
    chk("wr_busy_clr", 32'(bif.busy), 32'h0);
    chk("wr_d_hold", 32'(bif.reg_d), 32'hA);

    // Requester 0 reads address 5 back
    bif.req = 4'b0001; bif.req_we = 4'b0000;
    step();
    chk("rd_cs", 32'(bif.reg_cs), 32'hDF);
    chk("rd_ce", 32'(bif.reg_ce), 32'h0);
    chk("rd_grant", 32'(bif.grant), 32'h1);
    chk("rd_done_early", 32'(bif.done), 32'h0);
    step();
    chk("rd_done", 32'(bif.done), 32'h1);
    chk("rd_rdata", 32'(bif.rdata), 32'hA);
    chk("rd_cs_off", 32'(bif.reg_cs), 32'hFF);
    bif.req = 4'b0000;
    step();
    chk("rd_rdata_hold", 32'(bif.rdata), 32'hA);
    chk("rd_done_clr", 32'(bif.done), 32'h0);

    // Requester 2 writes address 2; reset lands mid-ACCESS
    bif.req = 4'b0100; bif.req_we = 4'b0100;
    bif.req_addr[8:6] = 3'd2; bif.req_wdata[11:8] = 4'h5;
    step();
    chk("ar_ce", 32'(bif.reg_ce), 32'h04);
    chk("ar_grant", 32'(bif.grant), 32'h4);
    #2 Reset = 1'b1;
    #1;
    chk("ar_ce_async", 32'(bif.reg_ce), 32'h0);
    chk("ar_grant_async", 32'(bif.grant), 32'h0);
    chk("ar_cs_async", 32'(bif.reg_cs), 32'hFF);
    chk("ar_busy_async", 32'(bif.busy), 32'h0);
    chk("ar_rdata_async", 32'(bif.rdata), 32'h0);
    bif.req = 4'b0000;
    step();
    chk("ar_bank2", 32'(bank[2]), 32'h0);
    chk("ar_count2", 32'(wcount[2]), 32'd0);
    Reset = 1'b0;

    // All four requesters held: fresh pointer starts at requester 0
    bif.req = 4'b1111; bif.req_we = 4'b0000; bif.req_addr = '0;
    for (int k = 0; k < 5; k++) begin
      exp = 32'd1 << (k % 4);
      step();
      chk("rr_grant", 32'(bif.grant), exp);
      step();
      chk("rr_grant_hold", 32'(bif.grant), exp);
      chk("rr_done", 32'(bif.done), 32'h1);
      step();
      chk("rr_idle_grant", 32'(bif.grant), 32'h0);
    end
    bif.req = 4'b0000;

    // Tick high one cycle in three during a write by requester 1
    bif.req = 4'b0010; bif.req_we = 4'b0010;
    bif.req_addr[5:3] = 3'd3; bif.req_wdata[7:4] = 4'h7;
    step();
    chk("tg_grant", 32'(bif.grant), 32'h2);
    chk("tg_ce", 32'(bif.reg_ce), 32'h08);
    chk("tg_d", 32'(bif.reg_d), 32'h7);
    Tick = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("tg_ce_hold", 32'(bif.reg_ce), 32'h08);
      chk("tg_done_wait", 32'(bif.done), 32'h0);
    end
    Tick = 1'b1;
    step();
    chk("tg_done", 32'(bif.done), 32'h1);
    chk("tg_ce_off", 32'(bif.reg_ce), 32'h0);
    Tick = 1'b0;
    bif.req = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("tg_done_hold", 32'(bif.done), 32'h1);
    end
    Tick = 1'b1;
    step();
    chk("tg_done_end", 32'(bif.done), 32'h0);
    chk("tg_count3", 32'(wcount[3]), 32'd1);
    chk("tg_bank3", 32'(bank[3]), 32'h7);

    // Six-register instance: valid read of address 1, then address 7
    bif6.req = 4'b0001; bif6.req_we = 4'b0000; bif6.req_addr[2:0] = 3'd1;
    step();
    chk("oor_valid_cs", 32'(bif6.reg_cs), 32'h3D);
    step();
    chk("oor_valid_done", 32'(bif6.done), 32'h1);
    chk("oor_valid_rdata", 32'(bif6.rdata), 32'hC);
    chk("oor_valid_err", 32'(bif6.err), 32'h0);
    bif6.req = 4'b0000;
    step();
    bif6.req = 4'b0001; bif6.req_addr[2:0] = 3'd7;
    step();
    chk("oor_cs", 32'(bif6.reg_cs), 32'h3F);
    chk("oor_ce", 32'(bif6.reg_ce), 32'h0);
    chk("oor_busy", 32'(bif6.busy), 32'h1);
    step();
    chk("oor_done", 32'(bif6.done), 32'h1);
    chk("oor_err", 32'(bif6.err), 32'h1);
    chk("oor_rdata", 32'(bif6.rdata), 32'h0);
    bif6.req = 4'b0000;
    step();
    chk("oor_err_clr", 32'(bif6.err), 32'h0);
    chk("oor_done_clr", 32'(bif6.done), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
